// File: rtl/i2c_config_sequencer_pkg.sv
// Shared definitions for the I2C configuration sequencer.
//   seq_state_e : sequencer FSM states
//   FAIL_CH_W   : width of the failing-channel index (and of the channel cursor)
//   ARM_HOLD    : cycles CH_RESET[cur] is held low (or high, on retry) before moving on
//   HOLD_W      : width of the hold counter
package i2c_config_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_LAUNCH,
        ST_WAIT,
        ST_NEXT,
        ST_DONE,
        ST_FAIL,
        ST_RETRY
    } seq_state_e;

    localparam int FAIL_CH_W = 3;
    localparam int ARM_HOLD  = 2;
    localparam int HOLD_W    = 2;

endpackage

// File: rtl/i2c_tick_gen.sv
// Free-running bit-rate enable generator.
//   CLK_50 : system clock
//   RESET  : asynchronous active-high reset
//   TICK   : one-cycle pulse every CLK_HZ/TICK_HZ clocks, registered
module i2c_tick_gen #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 400_000
) (
    input  logic CLK_50,
    input  logic RESET,
    output logic TICK
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    always_comb begin
        tick_d = (cnt_q == CW'(DIV - 1));
        cnt_d  = tick_d ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge CLK_50 or posedge RESET) begin
        if (RESET) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign TICK = tick_q;

endmodule

// File: rtl/i2c_config_sequencer.sv
// Runs NUM_CH I2C configuration engines one after another, releasing each
// from reset, starting it, and waiting for done / error / timeout.
//   CLK_50, RESET      : clock, asynchronous active-high reset
//   RESTART            : one-cycle pulse, rerun the whole sequence from channel 0
//   TICK_400K          : shared bit-rate enable for the engines
//   CH_RESET/CH_START  : per-engine hold reset and start pulse
//   CH_DONE/CH_ERR     : per-engine completion / error pulses
//   CH_RELEASE         : sticky per-channel completion flags
//   ALL_RELEASE        : every channel completed
//   FAIL/FAIL_CH       : sticky abort flag and the channel that caused it
// Build option: define CFG_SEQ_RETRY_EN to retry a failing channel up to
// MAX_RETRY times before aborting.
module i2c_config_sequencer
    import i2c_config_sequencer_pkg::*;
#(
    parameter int NUM_CH        = 2,
    parameter int CLK_HZ        = 50_000_000,
    parameter int TICK_HZ       = 400_000,
    parameter int TIMEOUT_TICKS = 65535,
    parameter int MAX_RETRY     = 3
) (
    input  logic                 CLK_50,
    input  logic                 RESET,
    input  logic                 RESTART,
    output logic                 TICK_400K,
    output logic [NUM_CH-1:0]    CH_RESET,
    output logic [NUM_CH-1:0]    CH_START,
    input  logic [NUM_CH-1:0]    CH_DONE,
    input  logic [NUM_CH-1:0]    CH_ERR,
    output logic [NUM_CH-1:0]    CH_RELEASE,
    output logic                 ALL_RELEASE,
    output logic                 FAIL,
    output logic [FAIL_CH_W-1:0] FAIL_CH
);

    localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);

    if (NUM_CH < 1 || NUM_CH > 8 || TIMEOUT_TICKS < 1 || MAX_RETRY < 0) begin : g_bad_param
        $error("i2c_config_sequencer: parameter out of range");
    end

    logic tick;

    i2c_tick_gen #(
        .CLK_HZ (CLK_HZ),
        .TICK_HZ(TICK_HZ)
    ) u_tick_gen (
        .CLK_50(CLK_50),
        .RESET (RESET),
        .TICK  (tick)
    );

    assign TICK_400K = tick;

    seq_state_e           state_q, state_d;
    logic [FAIL_CH_W-1:0] cur_q, cur_d, cur_inc;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [TO_W-1:0]      to_q, to_d;
    logic                 pend_q, pend_d;
    logic [NUM_CH-1:0]    ch_reset_q, ch_reset_d;
    logic [NUM_CH-1:0]    ch_start_q, ch_start_d;
    logic [NUM_CH-1:0]    ch_release_q, ch_release_d;
    logic                 all_release_q, all_release_d;
    logic                 fail_q, fail_d;
    logic [FAIL_CH_W-1:0] fail_ch_q, fail_ch_d;

`ifdef CFG_SEQ_RETRY_EN
    localparam int RT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RT_W-1:0] retry_q, retry_d;
`endif

    logic [NUM_CH-1:0] cur_mask, inc_mask;
    logic              sel_done, sel_err, timed_out, in_arm_launch, take_fail;

    // Shift-based one-hot masks avoid indexing a NUM_CH vector with a 3-bit cursor.
    assign cur_inc       = cur_q + FAIL_CH_W'(1);
    assign cur_mask      = NUM_CH'(1) << cur_q;
    assign inc_mask      = NUM_CH'(1) << cur_inc;
    assign sel_done      = |(CH_DONE & cur_mask);
    assign sel_err       = |(CH_ERR & cur_mask);
    assign timed_out     = (to_q == TO_W'(TIMEOUT_TICKS));
    assign in_arm_launch = (state_q == ST_ARM) || (state_q == ST_LAUNCH);

    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        hold_d       = hold_q;
        to_d         = to_q;
        pend_d       = pend_q;
        ch_reset_d   = ch_reset_q;
        ch_start_d   = '0;
        ch_release_d = ch_release_q;
        fail_d       = fail_q;
        fail_ch_d    = fail_ch_q;
        take_fail    = 1'b0;
`ifdef CFG_SEQ_RETRY_EN
        retry_d      = retry_q;
`endif

        // A restart arriving while an engine is being armed/launched is held
        // back and acted on once the sequencer reaches WAIT.
        if (in_arm_launch) begin
            pend_d = pend_q | RESTART;
        end

        if (!in_arm_launch && (RESTART || pend_q)) begin
            // IDLE drives every CH_RESET high for one cycle, then arms channel 0.
            state_d      = ST_IDLE;
            cur_d        = '0;
            hold_d       = '0;
            pend_d       = 1'b0;
            ch_reset_d   = '1;
            ch_release_d = '0;
            fail_d       = 1'b0;
            fail_ch_d    = '0;
`ifdef CFG_SEQ_RETRY_EN
            retry_d      = '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d    = ST_ARM;
                    hold_d     = '0;
                    ch_reset_d = ch_reset_q & ~cur_mask;
                end
                ST_ARM: begin
                    if (hold_q == HOLD_W'(ARM_HOLD - 1)) begin
                        state_d    = ST_LAUNCH;
                        ch_start_d = cur_mask;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                ST_LAUNCH: begin
                    state_d = ST_WAIT;
                    to_d    = '0;
                end
                ST_WAIT: begin
                    if (tick && !timed_out) begin
                        to_d = to_q + TO_W'(1);
                    end
                    if (sel_done) begin
                        ch_release_d = ch_release_q | cur_mask;
                        state_d      = ST_NEXT;
                    end else if (sel_err || timed_out) begin
`ifdef CFG_SEQ_RETRY_EN
                        if (retry_q < RT_W'(MAX_RETRY)) begin
                            retry_d    = retry_q + RT_W'(1);
                            ch_reset_d = ch_reset_q | cur_mask;
                            hold_d     = '0;
                            state_d    = ST_RETRY;
                        end else begin
                            take_fail = 1'b1;
                        end
`else
                        take_fail = 1'b1;
`endif
                    end
                end
                ST_NEXT: begin
                    if (cur_q == FAIL_CH_W'(NUM_CH - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        cur_d      = cur_inc;
                        hold_d     = '0;
                        ch_reset_d = ch_reset_q & ~inc_mask;
                        state_d    = ST_ARM;
`ifdef CFG_SEQ_RETRY_EN
                        retry_d    = '0;
`endif
                    end
                end
                ST_RETRY: begin
                    if (hold_q == HOLD_W'(ARM_HOLD - 1)) begin
                        hold_d     = '0;
                        ch_reset_d = ch_reset_q & ~cur_mask;
                        state_d    = ST_ARM;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                ST_DONE, ST_FAIL: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (take_fail) begin
                state_d    = ST_FAIL;
                fail_d     = 1'b1;
                fail_ch_d  = cur_q;
                ch_reset_d = ch_reset_q | cur_mask;
            end
        end

        all_release_d = &ch_release_d;
    end

    always_ff @(posedge CLK_50 or posedge RESET) begin
        if (RESET) begin
            state_q       <= ST_IDLE;
            cur_q         <= '0;
            hold_q        <= '0;
            to_q          <= '0;
            pend_q        <= 1'b0;
            ch_reset_q    <= '1;
            ch_start_q    <= '0;
            ch_release_q  <= '0;
            all_release_q <= 1'b0;
            fail_q        <= 1'b0;
            fail_ch_q     <= '0;
`ifdef CFG_SEQ_RETRY_EN
            retry_q       <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cur_q         <= cur_d;
            hold_q        <= hold_d;
            to_q          <= to_d;
            pend_q        <= pend_d;
            ch_reset_q    <= ch_reset_d;
            ch_start_q    <= ch_start_d;
            ch_release_q  <= ch_release_d;
            all_release_q <= all_release_d;
            fail_q        <= fail_d;
            fail_ch_q     <= fail_ch_d;
`ifdef CFG_SEQ_RETRY_EN
            retry_q       <= retry_d;
`endif
        end
    end

    assign CH_RESET    = ch_reset_q;
    assign CH_START    = ch_start_q;
    assign CH_RELEASE  = ch_release_q;
    assign ALL_RELEASE = all_release_q;
    assign FAIL        = fail_q;
    assign FAIL_CH     = fail_ch_q;

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Bench for i2c_config_sequencer with NUM_CH=3 and TIMEOUT_TICKS=4.
// Behavioural engines answer each CH_START after 10 clocks; every CH_DONE
// they issue pushes the expected CH_RELEASE value and arrival cycle onto a
// queue that is popped when CH_RELEASE gains bits.
module tb_i2c_config_sequencer;

    localparam int NCH = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       restart = 1'b0;
    logic       tick;
    logic [2:0] ch_reset, ch_start, ch_done, ch_err, ch_release, fail_ch;
    logic       all_release, fail;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    i2c_config_sequencer #(
        .NUM_CH       (NCH),
        .CLK_HZ       (50_000_000),
        .TICK_HZ      (400_000),
        .TIMEOUT_TICKS(4),
        .MAX_RETRY    (3)
    ) dut (
        .CLK_50     (clk),
        .RESET      (rst),
        .RESTART    (restart),
        .TICK_400K  (tick),
        .CH_RESET   (ch_reset),
        .CH_START   (ch_start),
        .CH_DONE    (ch_done),
        .CH_ERR     (ch_err),
        .CH_RELEASE (ch_release),
        .ALL_RELEASE(all_release),
        .FAIL       (fail),
        .FAIL_CH    (fail_ch)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Engine behaviour, set by the main sequence before each reset.
    logic [2:0] cfg_err_once = '0;
    logic [2:0] cfg_silent = '0;
    logic [2:0] cfg_both = '0;
    logic       cfg_spur = 1'b0;

    typedef struct {
        logic [2:0] rel;
        int         cyc;
    } rel_exp_t;
    rel_exp_t exp_q[$];

    int         starts[NCH];
    int         cnt[NCH];
    logic [2:0] err_pend, model_rel, prev_rel;
    logic       started2;
    int         tick_cnt2;

    // Engine models plus release monitor, one process to keep ordering fixed.
    initial begin
        rel_exp_t e;
        ch_done = '0; ch_err = '0; prev_rel = '0; model_rel = '0;
        err_pend = '0; started2 = 1'b0; tick_cnt2 = 0;
        for (int c = 0; c < NCH; c++) begin starts[c] = 0; cnt[c] = 0; end
        forever begin
            @(negedge clk);
            if ((ch_release & ~prev_rel) != 3'b000) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL release_unexpected actual=%b required=%b", ch_release, prev_rel);
                end else begin
                    e = exp_q.pop_front();
                    chk("release_value", int'(ch_release), int'(e.rel));
                    chk("release_cycle", cyc, e.cyc);
                end
            end
            prev_rel = ch_release;
            ch_done = '0;
            ch_err = '0;
            if (rst) begin
                for (int c = 0; c < NCH; c++) begin starts[c] = 0; cnt[c] = 0; end
                err_pend = cfg_err_once; model_rel = '0; exp_q.delete();
                started2 = 1'b0; tick_cnt2 = 0;
            end else begin
                if (restart) model_rel = '0;
                if (started2 && tick) tick_cnt2++;
                for (int c = 0; c < NCH; c++) begin
                    if (ch_start[c]) begin
                        starts[c]++;
                        cnt[c] = 10;
                        if (c == 2) started2 = 1'b1;
                    end else if (cnt[c] > 0) begin
                        cnt[c]--;
                        if (cnt[c] == 0 && !cfg_silent[c]) begin
                            if (err_pend[c]) begin
                                ch_err[c] = 1'b1;
                                err_pend[c] = 1'b0;
                            end else begin
                                ch_done[c] = 1'b1;
                                if (cfg_both[c]) ch_err[c] = 1'b1;
                                model_rel[c] = 1'b1;
                                exp_q.push_back('{model_rel, cyc + 1});
                            end
                        end
                    end
                end
                if (cfg_spur && cnt[0] == 5) ch_done[2] = 1'b1;
            end
        end
    end

    typedef struct {
        string      name;
        logic [2:0] err_once, silent, both;
        logic       spur;
        int         st0, st1, st2;
        logic [2:0] rel, chrst;
        logic       all, fl;
        logic [2:0] fch;
        int         ticks;
    } scen_t;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_end(input string name, output int ticks_at_end);
        bit seen = 0;
        ticks_at_end = -1;
        for (int g = 0; g < 3000; g++) begin
            @(negedge clk);
            if (all_release || fail) begin seen = 1; ticks_at_end = tick_cnt2; break; end
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL %s_end_timeout actual=none required=ALL_RELEASE or FAIL", name);
        end
    endtask

    initial begin
        scen_t tbl[4];
        int n0, tks;
        bit found;
        logic [2:0] seen_start;

        tbl[0] = '{"normal", 3'b000, 3'b000, 3'b000, 1'b0, 1, 1, 1, 3'b111, 3'b000, 1'b1, 1'b0, 3'd0, -1};
`ifdef CFG_SEQ_RETRY_EN
        tbl[1] = '{"err_ch1", 3'b010, 3'b000, 3'b000, 1'b0, 1, 2, 1, 3'b111, 3'b000, 1'b1, 1'b0, 3'd0, -1};
`else
        tbl[1] = '{"err_ch1", 3'b010, 3'b000, 3'b000, 1'b0, 1, 1, 0, 3'b001, 3'b110, 1'b0, 1'b1, 3'd1, -1};
`endif
        tbl[2] = '{"silent_ch2", 3'b000, 3'b100, 3'b000, 1'b0, 1, 1, 1, 3'b011, 3'b100, 1'b0, 1'b1, 3'd2, 4};
        tbl[3] = '{"done_err_spur", 3'b000, 3'b000, 3'b001, 1'b1, 1, 1, 1, 3'b111, 3'b000, 1'b1, 1'b0, 3'd0, -1};

        // Reset values, applied asynchronously.
        #2 rst = 1'b1;
        #1;
        chk("rst_ch_reset", int'(ch_reset), 7);
        chk("rst_ch_start", int'(ch_start), 0);
        chk("rst_release", int'(ch_release), 0);
        chk("rst_all", int'(all_release), 0);
        chk("rst_fail", int'(fail), 0);
        chk("rst_fail_ch", int'(fail_ch), 0);
        chk("rst_tick", int'(tick), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n0 = cyc;

        // Startup: ARM one cycle after release, CH_START[0] two cycles later.
        @(negedge clk);
        chk("start_arm_ch_reset", int'(ch_reset), 6);
        chk("start_arm_ch_start", int'(ch_start), 0);
        @(negedge clk);
        chk("start_hold_ch_start", int'(ch_start), 0);
        @(negedge clk);
        chk("start_launch_ch_start", int'(ch_start), 1);
        chk("start_launch_ch_reset", int'(ch_reset), 6);
        @(negedge clk);
        chk("start_wait_ch_start", int'(ch_start), 0);

        // Divider period from reset release.
        for (int k = 1; k <= 3; k++) begin
            found = 0;
            for (int g = 0; g < 200; g++) begin
                @(negedge clk);
                if (tick) begin found = 1; break; end
            end
            chk("tick_found", int'(found), 1);
            chk("tick_period", cyc - n0, 125 * k);
        end

        // Table-driven full sequences.
        for (int i = 0; i < 4; i++) begin
            cfg_err_once = tbl[i].err_once;
            cfg_silent   = tbl[i].silent;
            cfg_both     = tbl[i].both;
            cfg_spur     = tbl[i].spur;
            do_reset();
            wait_end(tbl[i].name, tks);
            if (tbl[i].ticks >= 0) chk({tbl[i].name, "_timeout_ticks"}, tks, tbl[i].ticks);
            repeat (5) @(negedge clk);
            chk({tbl[i].name, "_starts0"}, starts[0], tbl[i].st0);
            chk({tbl[i].name, "_starts1"}, starts[1], tbl[i].st1);
            chk({tbl[i].name, "_starts2"}, starts[2], tbl[i].st2);
            chk({tbl[i].name, "_release"}, int'(ch_release), int'(tbl[i].rel));
            chk({tbl[i].name, "_ch_reset"}, int'(ch_reset), int'(tbl[i].chrst));
            chk({tbl[i].name, "_all"}, int'(all_release), int'(tbl[i].all));
            chk({tbl[i].name, "_fail"}, int'(fail), int'(tbl[i].fl));
            chk({tbl[i].name, "_fail_ch"}, int'(fail_ch), int'(tbl[i].fch));
            chk({tbl[i].name, "_pending"}, exp_q.size(), 0);
        end

        // RESTART from DONE.
        cfg_err_once = '0; cfg_silent = '0; cfg_both = '0; cfg_spur = 1'b0;
        do_reset();
        wait_end("restart_first", tks);
        repeat (3) @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("restart_ch_reset", int'(ch_reset), 7);
        chk("restart_release", int'(ch_release), 0);
        chk("restart_all", int'(all_release), 0);
        chk("restart_fail", int'(fail), 0);
        @(negedge clk);
        chk("restart_arm_ch_reset", int'(ch_reset), 6);
        wait_end("restart_second", tks);
        repeat (5) @(negedge clk);
        chk("restart_starts0", starts[0], 2);
        chk("restart_starts2", starts[2], 2);
        chk("restart_final_release", int'(ch_release), 7);

        // RESET while channel 1 is in WAIT.
        do_reset();
        found = 0;
        for (int g = 0; g < 500; g++) begin
            @(negedge clk);
            if (starts[1] > 0) begin found = 1; break; end
        end
        chk("midrst_ch1_started", int'(found), 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_ch_reset", int'(ch_reset), 7);
        chk("midrst_ch_start", int'(ch_start), 0);
        chk("midrst_release", int'(ch_release), 0);
        chk("midrst_all", int'(all_release), 0);
        chk("midrst_fail", int'(fail), 0);
        chk("midrst_fail_ch", int'(fail_ch), 0);
        chk("midrst_tick", int'(tick), 0);
        seen_start = '0;
        repeat (20) begin
            @(negedge clk);
            seen_start = seen_start | ch_start;
        end
        chk("midrst_no_start", int'(seen_start), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
